// File: rtl/stopwatch_ctrl_pkg.sv
// Shared types and constants for the stopwatch controller slice.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  localparam logic [3:0]  BCD_MAX      = 4'd9;
  localparam int unsigned DEF_TICK_DIV = 50_000_000;

  // Value a BCD digit takes after an optional increment (9 wraps to 0).
  function automatic logic [3:0] bcd_next(input logic [3:0] d, input logic en);
    if (!en)
      return d;
    return (d == BCD_MAX) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Button inputs and display/status outputs of the stopwatch controller.
interface stopwatch_ctrl_if;
  logic       start_stop;
  logic       clear;
  logic       lap;
  logic [3:0] digit0;
  logic [3:0] digit1;
  logic       running;
  logic       tick;
  logic       wrap;
  logic       lap_active;

  modport master (
    output start_stop, clear, lap,
    input  digit0, digit1, running, tick, wrap, lap_active
  );

  modport slave (
    input  start_stop, clear, lap,
    output digit0, digit1, running, tick, wrap, lap_active
  );
endinterface

// File: rtl/stopwatch_ctrl_bcd_digit_sync.sv
// Single synchronous BCD digit (0..9) with clear, enable and carry-out.
module bcd_digit_sync
  import stopwatch_pkg::*;
(
  input  logic       fastclock,
  input  logic       resetn,
  input  logic       clr,
  input  logic       en,
  output logic [3:0] q,
  output logic       co
);

  always_ff @(posedge fastclock) begin
    if (!resetn)
      q <= '0;
    else if (clr)
      q <= '0;
    else
      q <= bcd_next(q, en);
  end

  assign co = en & (q == BCD_MAX);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Start/pause/clear stopwatch: prescaler, two BCD digits, registered status.
// Optional lap freeze enabled by defining STOPWATCH_LAP_EN.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICK_DIV = DEF_TICK_DIV,
  parameter int unsigned PRE_W    = 26
) (
  input  logic             fastclock,
  input  logic             resetn,
  stopwatch_ctrl_if.slave  sw
);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  state_t           state, state_nxt;
  logic [PRE_W-1:0] pre, pre_nxt;
  logic             ss_q, ss_rise;
  logic             inc;
  logic [3:0]       units, tens, u_nxt, t_nxt;
  logic             u_co, t_co;
  logic             lap_act, lap_act_nxt;
  logic [3:0]       disp0_nxt, disp1_nxt;
  logic [3:0]       digit0_q, digit1_q;
  logic             running_q, tick_q, wrap_q;

  always_comb begin
    ss_rise   = sw.start_stop & ~ss_q;
    state_nxt = state;
    pre_nxt   = pre;
    inc       = 1'b0;
    if (sw.clear) begin
      state_nxt = ST_IDLE;
      pre_nxt   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ss_rise) begin
            state_nxt = ST_RUN;
            pre_nxt   = '0;
          end
        end
        ST_RUN: begin
          // A pause on the terminal count still lets that increment land.
          if (pre == PRE_LAST) begin
            pre_nxt = '0;
            inc     = 1'b1;
          end else begin
            pre_nxt = pre + PRE_W'(1);
          end
          if (ss_rise)
            state_nxt = ST_PAUSE;
        end
        ST_PAUSE: begin
          if (ss_rise)
            state_nxt = ST_RUN;
        end
        default: begin
          state_nxt = ST_IDLE;
          pre_nxt   = '0;
        end
      endcase
    end
  end

  bcd_digit_sync u_units (
    .fastclock (fastclock),
    .resetn    (resetn),
    .clr       (sw.clear),
    .en        (inc),
    .q         (units),
    .co        (u_co)
  );

  bcd_digit_sync u_tens (
    .fastclock (fastclock),
    .resetn    (resetn),
    .clr       (sw.clear),
    .en        (u_co),
    .q         (tens),
    .co        (t_co)
  );

  // Post-edge count, so displayed digits and lap snapshot match the counters.
  assign u_nxt = sw.clear ? 4'd0 : bcd_next(units, inc);
  assign t_nxt = sw.clear ? 4'd0 : bcd_next(tens, u_co);

`ifdef STOPWATCH_LAP_EN
  logic       lap_q, lap_rise;
  logic [3:0] snap0, snap1, snap0_nxt, snap1_nxt;

  always_comb begin
    lap_rise    = sw.lap & ~lap_q;
    lap_act_nxt = lap_act;
    snap0_nxt   = snap0;
    snap1_nxt   = snap1;
    if (sw.clear) begin
      lap_act_nxt = 1'b0;
    end else if (lap_rise) begin
      if (!lap_act && state == ST_RUN) begin
        lap_act_nxt = 1'b1;
        snap0_nxt   = u_nxt;
        snap1_nxt   = t_nxt;
      end else if (lap_act && (state == ST_RUN || state == ST_PAUSE)) begin
        lap_act_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge fastclock) begin
    if (!resetn) begin
      lap_q <= 1'b1;
      snap0 <= '0;
      snap1 <= '0;
    end else begin
      lap_q <= sw.lap;
      snap0 <= snap0_nxt;
      snap1 <= snap1_nxt;
    end
  end

  assign disp0_nxt = lap_act_nxt ? snap0_nxt : u_nxt;
  assign disp1_nxt = lap_act_nxt ? snap1_nxt : t_nxt;
`else
  assign lap_act_nxt = 1'b0;
  assign disp0_nxt   = u_nxt;
  assign disp1_nxt   = t_nxt;
`endif

  always_ff @(posedge fastclock) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      pre       <= '0;
      ss_q      <= 1'b1;
      lap_act   <= 1'b0;
      digit0_q  <= '0;
      digit1_q  <= '0;
      running_q <= 1'b0;
      tick_q    <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      pre       <= pre_nxt;
      ss_q      <= sw.start_stop;
      lap_act   <= lap_act_nxt;
      digit0_q  <= disp0_nxt;
      digit1_q  <= disp1_nxt;
      running_q <= (state_nxt == ST_RUN);
      tick_q    <= inc;
      wrap_q    <= u_co & (tens == BCD_MAX);
    end
  end

  assign sw.digit0     = digit0_q;
  assign sw.digit1     = digit1_q;
  assign sw.running    = running_q;
  assign sw.tick       = tick_q;
  assign sw.wrap       = wrap_q;
  assign sw.lap_active = lap_act;

  logic unused_t_co;
  assign unused_t_co = t_co;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl: TICK_DIV=4 main instance, TICK_DIV=1 secondary.
module tb_stopwatch_ctrl;
  import stopwatch_pkg::*;

  logic fastclock = 1'b0;
  logic resetn    = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 fastclock = ~fastclock;

  stopwatch_ctrl_if sw4 ();
  stopwatch_ctrl_if sw1 ();

  stopwatch_ctrl #(.TICK_DIV(4), .PRE_W(3)) dut4 (
    .fastclock (fastclock),
    .resetn    (resetn),
    .sw        (sw4.slave)
  );

  stopwatch_ctrl #(.TICK_DIV(1), .PRE_W(2)) dut1 (
    .fastclock (fastclock),
    .resetn    (resetn),
    .sw        (sw1.slave)
  );

`ifdef STOPWATCH_LAP_EN
  localparam bit LAP = 1'b1;
`else
  localparam bit LAP = 1'b0;
`endif

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge fastclock);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int ticks, wraps;
    sw4.start_stop = 1'b0; sw4.clear = 1'b0; sw4.lap = 1'b0;
    sw1.start_stop = 1'b0; sw1.clear = 1'b0; sw1.lap = 1'b0;

    // Reset state
    steps(3);
    chk("rst_digit0", sw4.digit0, 0);
    chk("rst_digit1", sw4.digit1, 0);
    chk("rst_running", sw4.running, 0);
    chk("rst_tick", sw4.tick, 0);
    chk("rst_wrap", sw4.wrap, 0);
    chk("rst_lap", sw4.lap_active, 0);
    resetn = 1'b1;
    step();

    // Start; ticks at 4, 8, 12 cycles after the RUN edge
    sw4.start_stop = 1'b1;
    step();
    sw4.start_stop = 1'b0;
    chk("start_running", sw4.running, 1);
    chk("start_tick", sw4.tick, 0);
    for (int n = 1; n <= 3; n++) begin
      ticks = 0;
      for (int k = 0; k < 3; k++) begin
        step();
        ticks += int'(sw4.tick);
      end
      chk("pre_tick_quiet", ticks, 0);
      step();
      chk("tick_n", sw4.tick, 1);
      chk("digit0_n", sw4.digit0, n);
      chk("digit1_n", sw4.digit1, 0);
    end

    // Run up to 99, then wrap
    ticks = 0; wraps = 0;
    for (int i = 0; i < 384; i++) begin
      step();
      ticks += int'(sw4.tick);
      wraps += int'(sw4.wrap);
    end
    chk("ticks_to_99", ticks, 96);
    chk("no_early_wrap", wraps, 0);
    chk("d0_99", sw4.digit0, 9);
    chk("d1_99", sw4.digit1, 9);
    steps(3);
    chk("wrap_pre", sw4.wrap, 0);
    step();
    chk("wrap_d0", sw4.digit0, 0);
    chk("wrap_d1", sw4.digit1, 0);
    chk("wrap_pulse", sw4.wrap, 1);
    chk("wrap_tick", sw4.tick, 1);
    chk("wrap_running", sw4.running, 1);
    step();
    chk("wrap_one_cycle", sw4.wrap, 0);
    chk("tick_one_cycle", sw4.tick, 0);

    // Pause leaving pre==2, hold 20 cycles, resume
    sw4.start_stop = 1'b1;
    step();
    sw4.start_stop = 1'b0;
    chk("pause_running", sw4.running, 0);
    ticks = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      ticks += int'(sw4.tick);
    end
    chk("pause_no_tick", ticks, 0);
    chk("pause_d0", sw4.digit0, 0);
    sw4.start_stop = 1'b1;
    step();
    sw4.start_stop = 1'b0;
    chk("resume_running", sw4.running, 1);
    step();
    chk("resume_tick_early", sw4.tick, 0);
    step();
    chk("resume_tick", sw4.tick, 1);
    chk("resume_d0", sw4.digit0, 1);

    // Run to 37, clear + start_stop on the terminal prescaler edge
    steps(144);
    chk("d1_37", sw4.digit1, 3);
    chk("d0_37", sw4.digit0, 7);
    steps(3);
    sw4.clear = 1'b1;
    sw4.start_stop = 1'b1;
    step();
    sw4.clear = 1'b0;
    chk("clr_running", sw4.running, 0);
    chk("clr_tick", sw4.tick, 0);
    chk("clr_d0", sw4.digit0, 0);
    chk("clr_d1", sw4.digit1, 0);
    step();
    chk("clr_held_ss", sw4.running, 0);
    resetn = 1'b0;
    steps(2);
    resetn = 1'b1;
    steps(3);
    chk("ss_held_reset", sw4.running, 0);
    sw4.start_stop = 1'b0;
    step();

    // Lap: snapshot at 12, live count continues to 15
    sw4.start_stop = 1'b1;
    step();
    sw4.start_stop = 1'b0;
    steps(47);
    sw4.lap = 1'b1;
    step();
    sw4.lap = 1'b0;
    chk("lap_d1", sw4.digit1, 1);
    chk("lap_d0", sw4.digit0, 2);
    chk("lap_act", sw4.lap_active, LAP ? 1 : 0);
    steps(4);
    chk("lap_13", sw4.digit0, LAP ? 2 : 3);
    steps(4);
    chk("lap_14", sw4.digit0, LAP ? 2 : 4);
    steps(4);
    chk("lap_15", sw4.digit0, LAP ? 2 : 5);
    chk("lap_act_hold", sw4.lap_active, LAP ? 1 : 0);
    sw4.lap = 1'b1;
    step();
    sw4.lap = 1'b0;
    chk("lap_rel_d0", sw4.digit0, 5);
    chk("lap_rel_d1", sw4.digit1, 1);
    chk("lap_rel_act", sw4.lap_active, 0);

    // TICK_DIV=1: tick every cycle, one wrap after 100 cycles
    sw1.start_stop = 1'b1;
    step();
    sw1.start_stop = 1'b0;
    chk("td1_running", sw1.running, 1);
    chk("td1_start_tick", sw1.tick, 0);
    ticks = 0; wraps = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      ticks += int'(sw1.tick);
      wraps += int'(sw1.wrap);
    end
    chk("td1_ticks", ticks, 100);
    chk("td1_wraps", wraps, 1);
    chk("td1_d0", sw1.digit0, 0);
    chk("td1_d1", sw1.digit1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
